// File: rtl/mfm_bit_assembler.sv
// MFM cell shifter, A1/C2 sync-mark aligner and byte deframer behind the DPLL.
// Define MFM_ASM_CRC_EN to add the running CRC-CCITT outputs oCRC/oCRC_OK.
module mfm_bit_assembler #(
  parameter logic [15:0] SYNC_A = 16'h4489,
  parameter logic [15:0] SYNC_C = 16'h5224
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iRCLK,
  input  logic        iRAWR,
  input  logic        iSEARCH,
  output logic [7:0]  oDATA,
  output logic        oDRDY,
  output logic        oMARK,
  output logic        oLOCK,
  output logic        oCELLERR
`ifdef MFM_ASM_CRC_EN
  ,
  output logic [15:0] oCRC,
  output logic        oCRC_OK
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_rclk_q;
  logic        r_pend;
  logic        r_edge_d;
  logic [15:0] r_raw;
  logic [3:0]  r_cnt;

  logic        w_edge;
  logic        w_match;
  logic        w_emit_mk;
  logic        w_emit_dt;
  logic [7:0]  w_dec;

  assign w_edge = iRCLK ^ r_rclk_q;

  assign w_match = r_edge_d &
                   ((r_raw == SYNC_A) | (r_raw == SYNC_C));

  assign w_emit_mk = iSEARCH & w_match;

  assign w_emit_dt = iSEARCH & r_edge_d & ~w_match &
                     (r_state == LOCKED) & (r_cnt == 4'd15);

  assign oLOCK = (r_state == LOCKED);

  // data cells sit at the even positions, raw[14] is the byte MSB
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < 8; i++) begin
      w_dec[i] = r_raw[2*i];
    end
  end

  // a pulse coinciding with an edge belongs to the next cell
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_rclk_q <= 1'b0;
      r_pend   <= 1'b0;
      r_raw    <= '0;
      r_edge_d <= 1'b0;
    end else begin
      r_rclk_q <= iRCLK;
      r_edge_d <= w_edge;
      if (w_edge) begin
        r_raw  <= {r_raw[14:0], r_pend};
        r_pend <= iRAWR;
      end else if (iRAWR) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state  <= HUNT;
      r_cnt    <= '0;
      oDATA    <= '0;
      oDRDY    <= 1'b0;
      oMARK    <= 1'b0;
      oCELLERR <= 1'b0;
    end else begin
      oDRDY    <= 1'b0;
      oCELLERR <= 1'b0;
      if (!iSEARCH) begin
        r_state <= HUNT;
        r_cnt   <= '0;
      end else if (w_match) begin
        r_state <= LOCKED;
        r_cnt   <= '0;
        oDATA   <= w_dec;
        oMARK   <= 1'b1;
        oDRDY   <= 1'b1;
      end else if (r_edge_d && r_state == LOCKED) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_emit_dt) begin
          oDATA <= w_dec;
          oMARK <= 1'b0;
          oDRDY <= 1'b1;
        end
        if (r_raw[1:0] == 2'b11) begin
          oCELLERR <= 1'b1;
        end
      end
    end
  end

`ifdef MFM_ASM_CRC_EN
  function automatic logic [15:0] f_crc8(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] r_crc;
  logic        r_crc_pre;
  logic        r_last_mark;

  // the first mark of a run restarts the CRC; later marks accumulate
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_crc       <= 16'hFFFF;
      r_crc_pre   <= 1'b0;
      r_last_mark <= 1'b0;
    end else begin
      if (oDRDY) begin
        r_crc <= f_crc8(r_crc_pre ? 16'hFFFF : r_crc, oDATA);
      end
      if (w_emit_mk) begin
        r_crc_pre   <= (r_state == HUNT) | ~r_last_mark;
        r_last_mark <= 1'b1;
      end else if (w_emit_dt) begin
        r_crc_pre   <= 1'b0;
        r_last_mark <= 1'b0;
      end
    end
  end

  assign oCRC    = r_crc;
  assign oCRC_OK = (r_crc == 16'h0000);
`endif

endmodule

// File: tb/tb_mfm_bit_assembler.sv
// Scoreboard bench for mfm_bit_assembler: cell-stream model vs DUT byte strobes.
// Define MFM_ASM_CRC_EN to also exercise the CRC outputs.
module tb_mfm_bit_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rclk = 1'b0;
  logic       rawr = 1'b0;
  logic       search = 1'b0;
  logic [7:0] o_data;
  logic       o_drdy;
  logic       o_mark;
  logic       o_lock;
  logic       o_cellerr;
`ifdef MFM_ASM_CRC_EN
  logic [15:0] o_crc;
  logic        o_crc_ok;
`endif

  mfm_bit_assembler dut (
    .iCLK     (clk),
    .iRSTn    (rst_n),
    .iRCLK    (rclk),
    .iRAWR    (rawr),
    .iSEARCH  (search),
    .oDATA    (o_data),
    .oDRDY    (o_drdy),
    .oMARK    (o_mark),
    .oLOCK    (o_lock),
    .oCELLERR (o_cellerr)
`ifdef MFM_ASM_CRC_EN
    ,
    .oCRC     (o_crc),
    .oCRC_OK  (o_crc_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       m;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  exp_t        sbq[$];
  bit          cells[$];
  bit          enc_prev = 1'b0;
  logic [15:0] m_win = '0;
  bit          m_lock = 1'b0;
  int          m_since = 0;
  int          m_err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_drdy) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_drdy: got data %h mark %b, required none",
                   o_data, o_mark);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("data", {24'h0, o_data}, {24'h0, e.d});
          check("mark", {31'h0, o_mark}, {31'h0, e.m});
        end
      end
      if (o_cellerr) err_seen++;
    end
  end

  task automatic push_sync(input logic [15:0] p);
    for (int i = 15; i >= 0; i--) cells.push_back(p[i]);
    enc_prev = p[0];
  endtask

  // MFM: clock cell is 1 only between two zero data bits
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cells.push_back(!(enc_prev || b[i]));
      cells.push_back(b[i]);
      enc_prev = b[i];
    end
  endtask

  task automatic push_noise(input int n);
    for (int i = 0; i < n; i++) cells.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic model(input bit srch, input int drop);
    exp_t e;
    for (int k = 0; k < cells.size(); k++) begin
      if (k == drop) m_lock = 1'b0;
      m_win = {m_win[14:0], cells[k]};
      if (!srch) begin
        m_lock = 1'b0;
        continue;
      end
      for (int i = 0; i < 8; i++) e.d[i] = m_win[2*i];
      if (m_lock && m_win[1:0] == 2'b11) m_err++;
      if (m_win == 16'h4489 || m_win == 16'h5224) begin
        e.m = 1'b1;
        sbq.push_back(e);
        m_lock = 1'b1;
        m_since = 0;
      end else if (m_lock) begin
        m_since++;
        if (m_since == 16) begin
          e.m = 1'b0;
          sbq.push_back(e);
          m_since = 0;
        end
      end
    end
  endtask

  // mode 0: pulses inside window, 1: on the closing edge, 2: mixed
  task automatic drive(input bit srch, input int mode, input int drop);
    int n;
    int pj;
    model(srch, drop);
    search = srch;
    for (int k = 0; k < cells.size(); k++) begin
      n = $urandom_range(3, 6);
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) pj = 0;
      else pj = $urandom_range(1, n - 1);
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        if (j == 0 && k > 0) rclk = ~rclk;
        rawr = cells[k] && (j == pj);
        search = (k == drop && j == 2) ? 1'b0 : srch;
      end
    end
    @(negedge clk);
    rclk = ~rclk;
    rawr = 1'b0;
    search = srch;
    repeat (5) @(negedge clk);
    check("drained", sbq.size(), 0);
    check("lock", {31'h0, o_lock}, {31'h0, m_lock});
    check("cellerr_count", err_seen, m_err);
    cells.delete();
  endtask

`ifdef MFM_ASM_CRC_EN
  function automatic logic [15:0] crc_of(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[n]) begin
      for (int i = 7; i >= 0; i--) begin
        c = (c[15] ^ b[n][i]) ? ({c[14:0], 1'b0} ^ 16'h1021)
                              : {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic crc_frame(input bit flip);
    logic [7:0]  fr[$];
    logic [15:0] c;
    fr = '{8'hA1, 8'hA1, 8'hA1, 8'hFE, 8'h00, 8'h00, 8'h01, 8'h01};
    c = crc_of(fr);
    push_sync(16'h4489);
    push_sync(16'h4489);
    push_sync(16'h4489);
    for (int i = 3; i < 8; i++) begin
      if (flip && i == 5) push_byte(fr[i] ^ 8'h10);
      else push_byte(fr[i]);
    end
    push_byte(c[15:8]);
    push_byte(c[7:0]);
    drive(1'b1, 2, -1);
    check(flip ? "crc_ok_bad" : "crc_ok_good", {31'h0, o_crc_ok},
          {31'h0, !flip});
    if (!flip) check("crc_residue", {16'h0, o_crc}, 32'h0);
  endtask
`endif

  initial begin
    int nb;
    int ci;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, o_data}, 32'h0);
    check("rst_drdy", {31'h0, o_drdy}, 32'h0);
    check("rst_mark", {31'h0, o_mark}, 32'h0);
    check("rst_lock", {31'h0, o_lock}, 32'h0);
    check("rst_cellerr", {31'h0, o_cellerr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) cells.push_back(1'b0);
    drive(1'b1, 0, -1);
    check("idle_data", {24'h0, o_data}, 32'h0);

    for (int m = 0; m < 2; m++) begin
      push_sync(16'h4489);
      push_sync(16'h4489);
      push_sync(16'h4489);
      push_byte(8'hFE);
      drive(1'b1, m, -1);
    end

    push_sync(16'h4489);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    ci = 16 + $urandom_range(0, 40);
    cells[ci] = 1'b1;
    cells[ci + 1] = 1'b1;
    drive(1'b1, 2, -1);

    push_sync(16'h4489);
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    push_sync(16'h4489);
    push_byte(8'h5A);
    drive(1'b1, 2, 40);

    push_sync(16'h5224);
    push_byte(8'h3C);
    drive(1'b0, 0, -1);

    for (int t = 0; t < 20; t++) begin
      push_noise($urandom_range(0, 40));
      push_sync($urandom_range(0, 1) ? 16'h4489 : 16'h5224);
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) push_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        ci = $urandom_range(0, cells.size() - 2);
        cells[ci] = 1'b1;
        cells[ci + 1] = 1'b1;
      end
      drive(1'b1, $urandom_range(0, 2),
            ($urandom_range(0, 4) == 0) ? $urandom_range(0, 60) : -1);
    end

`ifdef MFM_ASM_CRC_EN
    push_noise(8);
    drive(1'b0, 0, -1);
    crc_frame(1'b0);
    crc_frame(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mfm_bit_assembler.md
Name: mfm_bit_assembler

Overview:
- Sits directly downstream of the VG93 digital PLL.
- Consumes the PLL's toggling read-window clock and single-cycle raw read pulses, and builds a 16-cell MFM stream from them.
- Detects missing-clock sync marks (A1/C2), aligns byte boundaries and delivers decoded bytes to the WD1793 read/sector logic.

Parameters:
- SYNC_A, 16'h4489, MFM cell pattern of A1 with missing clock (data/ID mark sync).
- SYNC_C, 16'h5224, MFM cell pattern of C2 with missing clock (index mark sync).

Ports:
- iCLK  input  1  system clock, same domain as DPLL.
- iRSTn  input  1  asynchronous active-low reset.
- iRCLK  input  1  read-window clock from DPLL; each edge (rise or fall) closes one bit cell.
- iRAWR  input  1  one-iCLK raw flux pulse from DPLL.
- iSEARCH  input  1  1 = hunt/locked operation enabled; 0 = force HUNT, suppress bytes.
- oDATA  output  8  decoded byte, held until next oDRDY.
- oDRDY  output  1  one-cycle strobe, oDATA valid.
- oMARK  output  1  qualifies oDRDY: byte came from a sync pattern.
- oLOCK  output  1  1 while in LOCKED.
- oCELLERR  output  1  one-cycle pulse on MFM rule violation (two adjacent 1 cells) while LOCKED.

Behaviour:
- Reset (async, iRSTn=0): oDATA=8'h00, oDRDY=0, oMARK=0, oLOCK=0, oCELLERR=0, cell shift reg=0, cell counter=0, pending=0, state=HUNT, iRCLK history reg=0.
- Window edge: register iRCLK once; edge = iRCLK != history.
- pending flag: set by iRAWR, cleared at each window edge.
- At a window edge, shift in pending (not the same-cycle iRAWR) at bit0 of raw[15:0]; raw[15] is the oldest cell.
- iRAWR coincident with an edge sets pending for the next window.
- Shift-in and pending-clear at the same edge: clear wins, then the new set applies.
- Data bits are raw[14],raw[12],…,raw[0], MSB first; clock bits are the odd positions.
- Sync match is evaluated on the raw value after the shift, in the cycle after the edge (1-cycle pipeline). Match = raw==SYNC_A or raw==SYNC_C.
- On a sync match with iSEARCH=1, in any state:
  - state=LOCKED, cell counter=0.
  - oDATA=decoded byte (A1 or C2), oMARK=1, oDRDY=1 for one cycle.
- Re-sync mid-byte realigns silently: the partial byte is discarded.
- LOCKED, no match: counter increments per edge, wraps 15→0. On wrap, oDATA=decoded byte, oMARK=0, oDRDY=1. Latency: strobe one iCLK after the 16th edge.
- oCELLERR: LOCKED and raw[1:0]==2'b11 after a shift; one-cycle pulse, no state change.
- iSEARCH=0: state=HUNT immediately (next iCLK), counter=0, no oDRDY. Shifting continues so sync can be found on re-enable.
- HUNT: no oDRDY except on sync match.
- oLOCK mirrors state.

Optional Feature:
- Macro: MFM_ASM_CRC_EN.
- With it defined, two extra outputs exist:
  - oCRC[15:0]: CRC-CCITT (poly 0x1021, MSB first).
  - oCRC_OK: oCRC==16'h0000.
- CRC preset to 16'hFFFF on any sync-match byte that follows a non-mark byte or a HUNT state.
- Every emitted byte, including marks, updates the CRC in the same cycle as oDRDY, so oCRC is valid one cycle after oDRDY.
- CRC reset value on iRSTn is 16'hFFFF.
- Without the macro, the ports and logic are absent.

Test Plan:
- Reset released, no pulses, iRCLK toggling 64 times → oDRDY never asserts, oLOCK=0, all outputs 0.
- iSEARCH=1, feed cells 4489 ×3 then MFM of 8'hFE → three strobes with oDATA=A1, oMARK=1, then oDATA=FE, oMARK=0; oLOCK=1 after the first.
- Same stream with iRAWR pulses asserted exactly on iRCLK edge cycles → pulses land in the following cell; stream built this way decodes correctly.
- Locked, inject cells "11" → oCELLERR one-cycle pulse; next byte boundary still emitted on schedule.
- Locked, drop iSEARCH for 1 cycle mid-byte → oLOCK=0, no oDRDY until the next 4489; then correct realignment.
- With MFM_ASM_CRC_EN: A1 A1 A1 FE 00 00 01 01 + correct CRC bytes → oCRC_OK=1 after last byte; flip one data bit → oCRC_OK=0.
